// File: rtl/subtrator8_serial.sv
// ============================================================================
//  Module      : subtrator8_serial
//  Description : Bit-serial N-bit subtractor D = A - B, one bit per clock,
//                borrow-out in D[N]. Optional flags: SUBTRATOR8_FLAGS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module subtrator8_serial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inicio,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N:0]   D,
    output logic         ocupado,
    output logic         pronto
`ifdef SUBTRATOR8_FLAGS_EN
    ,
    output logic         zero,
    output logic         neg,
    output logic         ovf
`endif
);

    localparam int              c_cnt_w   = $clog2(N);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    typedef enum logic [0:0] {
        OCIOSO     = 1'b0,
        SUBTRAINDO = 1'b1
    } state_t;

    state_t               r_state;
    logic [N-1:0]         r_a;
    logic [N-1:0]         r_b;
    logic [N-1:0]         r_res;
    logic                 r_bw;
    logic [c_cnt_w-1:0]   r_cnt;

    logic                 w_a;
    logic                 w_b;
    logic                 w_d;
    logic                 w_bw_next;
    logic [N-1:0]         w_res_final;
    logic                 w_last;

    // One full-subtractor cell shared across all bit positions.
    assign w_a         = r_a[0];
    assign w_b         = r_b[0];
    assign w_d         = w_a ^ w_b ^ r_bw;
    assign w_bw_next   = (~w_a & w_b) | (~(w_a ^ w_b) & r_bw);
    assign w_res_final = {w_d, r_res[N-1:1]};
    assign w_last      = (r_cnt == c_last);

`ifdef SUBTRATOR8_FLAGS_EN
    // Operand sign bits are kept aside because r_a/r_b are shifted away.
    logic r_a_msb;
    logic r_b_msb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OCIOSO;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_bw    <= 1'b0;
            r_cnt   <= '0;
            D       <= '0;
            ocupado <= 1'b0;
            pronto  <= 1'b0;
`ifdef SUBTRATOR8_FLAGS_EN
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            zero    <= 1'b0;
            neg     <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            pronto <= 1'b0;
            case (r_state)
                OCIOSO: begin
                    if (inicio) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_bw    <= 1'b0;
                        r_cnt   <= '0;
                        ocupado <= 1'b1;
                        r_state <= SUBTRAINDO;
`ifdef SUBTRATOR8_FLAGS_EN
                        r_a_msb <= A[N-1];
                        r_b_msb <= B[N-1];
`endif
                    end
                end
                SUBTRAINDO: begin
                    r_a   <= {1'b0, r_a[N-1:1]};
                    r_b   <= {1'b0, r_b[N-1:1]};
                    r_res <= w_res_final;
                    r_bw  <= w_bw_next;
                    r_cnt <= r_cnt + c_one;
                    if (w_last) begin
                        D       <= {w_bw_next, w_res_final};
                        pronto  <= 1'b1;
                        ocupado <= 1'b0;
                        r_state <= OCIOSO;
`ifdef SUBTRATOR8_FLAGS_EN
                        zero    <= (w_res_final == '0);
                        neg     <= w_d;
                        ovf     <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
`endif
                    end
                end
                default: r_state <= OCIOSO;
            endcase
        end
    end

endmodule

`default_nettype wire
